wb_queue: RTL and testbench
===========================

# wb_queue

Writeback queue between the execute/memory stages and the register-file write port. It accepts register writes from two producers, the ALU and the memory unit, over valid/ready handshakes. It buffers them in an in-order FIFO and drains one entry per cycle onto the register file's `we3`/`wa3`/`wd3` port. It also forwards pending, not-yet-written values onto the two read ports, so the decode stage never reads stale data.

## Interface
- `n`, 16, data width in bits (register width).
- `r`, 3, register address width; 2**r registers.
- `DEPTH`, 4, number of queue entries; must be a power of two and at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU has a write to deliver.
- `alu_wa`  in  r  ALU destination register.
- `alu_wd`  in  n  ALU result.
- `alu_ready`  out  1  ALU write accepted this cycle when high together with `alu_valid`.
- `mem_valid`  in  1  memory unit has a load result.
- `mem_wa`  in  r  load destination register.
- `mem_wd`  in  n  load data.
- `mem_ready`  out  1  load write accepted when high together with `mem_valid`.
- `we3`  out  1  register-file write enable.
- `wa3`  out  r  register-file write address.
- `wd3`  out  n  register-file write data.
- `ra1`, `ra2`  in  r  decode read addresses; these are the same addresses presented to the register file.
- `rf_rd1`, `rf_rd2`  in  n  raw register-file read data.
- `rd1`, `rd2`  out  n  forwarded read data for decode.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `full`, `empty`  out  1  `count==DEPTH` and `count==0` respectively.

## Operation
- **Storage.** Circular buffer with head and tail pointers, each `$clog2(DEPTH)` bits wide. Both pointers wrap from DEPTH-1 to 0.
- **Enqueue.** At most one enqueue per cycle. The memory unit has priority.
  - `mem_ready = !reset && !full`.
  - `alu_ready = !reset && !full && !mem_valid`.
  - A handshake (valid and ready both high) writes {wa, wd} at the tail and increments the tail.
- **Drain.** The regfile write port never stalls.
  - `we3 = !empty`; `wa3`/`wd3` show the head entry.
  - The head pops on every rising edge while `!empty`.
  - When empty, `wa3 = 0` and `wd3 = 0`.
- **Simultaneous enqueue and dequeue.** `count` is unchanged and both pointers advance.
- **Ready timing.** Ready depends only on the registered `count`. A full queue does not accept in the same cycle it drains; the slot frees for the next cycle.
- **Forwarding (combinational).**
  - `rd1` is the data of the youngest valid queued entry whose address equals `ra1`. The head entry is included, because the register file commits it only at the coming edge.
  - If no entry matches, `rd1 = rf_rd1`. `rd2` works the same way with `ra2`.
  - An entry enqueued in the current cycle is not forwarded.
- **Ordering.** Entries drain strictly in acceptance order. Repeated writes to the same register all reach the register file, and the last one wins.
- **Reset.**
  - Clears the pointers and `count` to 0.
  - Outputs are then `we3=0`, `wa3=0`, `wd3=0`, `empty=1`, `full=0`, `count=0`.
  - Both ready outputs are 0 in every cycle `reset` is high.
  - Entry contents are not cleared.
  - A reset mid-operation discards all pending entries without writing them.

## Timing
- **Write latency.** A write accepted at edge t appears on `we3`/`wa3`/`wd3` during cycle t+1. The register file commits it at edge t+1. The minimum is 1 cycle of queue residency.
- **Throughput.** One write per cycle, sustained.
- **Combinational outputs.** `rd1`/`rd2`, `alu_ready`, `mem_ready`, `we3`, `wa3` and `wd3` are combinational from state and inputs. There are no paths from `alu_wd`/`mem_wd` to `rd1`/`rd2`.

## Configuration
- **`WBQ_ZERO_DROP_EN` defined.**
  - A handshake with destination address 0 is accepted under the normal ready rules, but it is not enqueued and `count` does not change.
  - `rd1`/`rd2` return 0 whenever the read address is 0, regardless of `rf_rd*`.
- **`WBQ_ZERO_DROP_EN` undefined.** Address 0 is an ordinary register: it is queued, written and forwarded like any other.

## Test plan
- **Single write.** After reset, `alu_valid=1`, `alu_wa=3`, `alu_wd=16'h1234` for one cycle. Required response: next cycle `we3=1`, `wa3=3`, `wd3=16'h1234`; the cycle after, `empty=1`, `we3=0`.
- **Priority.** `mem_valid` and `alu_valid` both high, `mem_wa=1`/`16'hAAAA`, `alu_wa=2`/`16'h5555`. Required response: `alu_ready=0` and the mem entry drains first; the ALU is accepted the next cycle and drains second.
- **Full and wrap.** Hold the ALU valid with addresses 1..6 while `reset` is held for the first cycle. Required response:
  - `count` rises by net 0 per cycle once draining starts.
  - Run a burst with the drain path observed: `full` never asserts with 1-in/1-out.
  - Force a 4-cycle burst with both producers alternating and check that `alu_ready` drops whenever `mem_valid` is high.
  - Check that pointers wrap past index 3 with data intact.
- **Forwarding.** Enqueue r5=`16'h0001` then r5=`16'h0002` back to back, with `ra1=5` and `rf_rd1=16'hDEAD`. Required response: `rd1=16'h0001` for one cycle, then `16'h0002`, then `16'hDEAD` once empty.
- **Reset mid-operation.** Enqueue 3 entries, then assert `reset` for one cycle. Required response: `count=0`, `we3=0`, ready outputs 0 during reset, and no queued write appears afterwards.
- **Zero drop.** With `WBQ_ZERO_DROP_EN` defined, write r0=`16'hFFFF`. Required response: `alu_ready=1`, `count` stays 0, `we3` never asserts, and `rd1=0` with `ra1=0`. Without the macro: the entry drains to `wa3=0`.

Source files
------------

// File: rtl/wb_queue_if.sv
// Writeback queue bus: producer handshakes, register-file write port and
// decode read/forward signals, bundled for the queue and its surroundings.
interface wb_queue_if #(
    parameter int n = 16,
    parameter int r = 3
);
    // valid/ready: a transfer happens on a rising edge where both are high;
    // valid must not wait on ready, and ready is driven only by queue state.
    logic         alu_valid;
    logic [r-1:0] alu_wa;
    logic [n-1:0] alu_wd;
    logic         alu_ready;
    logic         mem_valid;
    logic [r-1:0] mem_wa;
    logic [n-1:0] mem_wd;
    logic         mem_ready;
    logic         we3;
    logic [r-1:0] wa3;
    logic [n-1:0] wd3;
    logic [r-1:0] ra1;
    logic [r-1:0] ra2;
    logic [n-1:0] rf_rd1;
    logic [n-1:0] rf_rd2;
    logic [n-1:0] rd1;
    logic [n-1:0] rd2;

    modport master (
        output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
               ra1, ra2, rf_rd1, rf_rd2,
        input  alu_ready, mem_ready, we3, wa3, wd3, rd1, rd2
    );

    modport slave (
        input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
               ra1, ra2, rf_rd1, rf_rd2,
        output alu_ready, mem_ready, we3, wa3, wd3, rd1, rd2
    );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: in-order FIFO of ALU/memory register writes, drained one per
// cycle to the register file, with read forwarding. Option: WBQ_ZERO_DROP_EN.
module wb_queue #(
    parameter int n     = 16,
    parameter int r     = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    wb_queue_if.slave                  bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [r-1:0]  wa_q [DEPTH];
    logic [n-1:0]  wd_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          mem_hs, alu_hs, do_enq, do_deq;
    logic [r-1:0]  enq_wa;
    logic [n-1:0]  enq_wd;
    logic [PW-1:0] fwd_idx;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

    // Ready sees only registered occupancy: a full queue frees its slot a cycle after draining.
    assign bus.mem_ready = !reset && !full;
    assign bus.alu_ready = !reset && !full && !bus.mem_valid;
    assign mem_hs = bus.mem_valid && bus.mem_ready;
    assign alu_hs = bus.alu_valid && bus.alu_ready;
    assign enq_wa = mem_hs ? bus.mem_wa : bus.alu_wa;
    assign enq_wd = mem_hs ? bus.mem_wd : bus.alu_wd;

`ifdef WBQ_ZERO_DROP_EN
    assign do_enq = (mem_hs || alu_hs) && (enq_wa != '0);
`else
    assign do_enq = mem_hs || alu_hs;
`endif
    assign do_deq = !empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_deq) head_d = head_q + PW'(1);
        if (do_enq) tail_d = tail_q + PW'(1);
        if (do_enq && !do_deq) begin
            count_d = count_q + CW'(1);
        end else if (!do_enq && do_deq) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            wa_q[tail_q] <= enq_wa;
            wd_q[tail_q] <= enq_wd;
        end
    end

    // Held off while reset is high so discarded entries never reach the register file.
    assign bus.we3 = !empty && !reset;
    assign bus.wa3 = bus.we3 ? wa_q[head_q] : '0;
    assign bus.wd3 = bus.we3 ? wd_q[head_q] : '0;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        bus.rd1 = bus.rf_rd1;
        bus.rd2 = bus.rf_rd2;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (wa_q[fwd_idx] == bus.ra1) bus.rd1 = wd_q[fwd_idx];
                if (wa_q[fwd_idx] == bus.ra2) bus.rd2 = wd_q[fwd_idx];
            end
        end
`ifdef WBQ_ZERO_DROP_EN
        if (bus.ra1 == '0) bus.rd1 = '0;
        if (bus.ra2 == '0) bus.rd2 = '0;
`endif
    end
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed vector table, hand sequences for reset and
// address-0 handling, then randomized traffic against a queue-based model.
module tb_wb_queue;
    localparam int N = 16;
    localparam int R = 3;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   count;
    logic         full, empty;
    int           total = 0;
    int           bad = 0;
    logic [R+N-1:0] exp_q[$];

    typedef struct {
        int rst, av, aw, ad, mv, mw, md, ra;
        int e_ar, e_mr, e_we, e_wa, e_wd, e_rd, e_cnt;
    } vec_t;
    vec_t vecs[$];

    wb_queue_if #(.n(N), .r(R)) bus ();

    wb_queue #(.n(N), .r(R), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int rst, input int av, input int aw, input int ad,
                         input int mv, input int mw, input int md,
                         input int ra1, input int ra2, input int rf1, input int rf2);
        reset         = (rst != 0);
        bus.alu_valid = (av != 0);
        bus.alu_wa    = R'(aw);
        bus.alu_wd    = N'(ad);
        bus.mem_valid = (mv != 0);
        bus.mem_wa    = R'(mw);
        bus.mem_wd    = N'(md);
        bus.ra1       = R'(ra1);
        bus.ra2       = R'(ra2);
        bus.rf_rd1    = N'(rf1);
        bus.rf_rd2    = N'(rf2);
    endtask

    function automatic vec_t mk(int rst, int av, int aw, int ad, int mv, int mw, int md, int ra,
                                int e_ar, int e_mr, int e_we, int e_wa, int e_wd, int e_rd, int e_cnt);
        vec_t v;
        v.rst = rst; v.av = av; v.aw = aw; v.ad = ad; v.mv = mv; v.mw = mw; v.md = md; v.ra = ra;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_rd = e_rd; v.e_cnt = e_cnt;
        return v;
    endfunction

    // Reference forwarding: youngest queued write to the address, else register file.
    function automatic logic [N-1:0] fwd(input logic [R-1:0] ra, input logic [N-1:0] rf);
        logic [N-1:0] v;
        v = rf;
        foreach (exp_q[i]) if (exp_q[i][R+N-1:N] == ra) v = exp_q[i][N-1:0];
`ifdef WBQ_ZERO_DROP_EN
        if (ra == '0) v = '0;
`endif
        return v;
    endfunction

    function automatic void model_push(input logic [R-1:0] wa, input logic [N-1:0] wd);
`ifdef WBQ_ZERO_DROP_EN
        if (wa == '0) return;
`endif
        exp_q.push_back({wa, wd});
    endfunction

    initial begin
        logic         rst, av, mv, e_full, e_mr, e_ar, e_we;
        logic [R-1:0] aw, mw, ra1, ra2, e_wa;
        logic [N-1:0] ad, md, rf1, rf2, e_wd;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.count", count, 0);
        chk("rst.empty", empty, 1);
        chk("rst.full", full, 0);
        chk("rst.we3", bus.we3, 0);
        chk("rst.wa3", bus.wa3, 0);
        chk("rst.wd3", bus.wd3, 0);
        chk("rst.alu_ready", bus.alu_ready, 0);
        chk("rst.mem_ready", bus.mem_ready, 0);
        @(posedge clk);
        #1;

        //            rst av aw ad       mv mw md       ra  ar mr we wa wd       rd1      cnt
        vecs.push_back(mk(1, 1, 1, 'h1111, 0, 0, 0,       3,  0, 0, 0, 0, 0,       'hDEAD, 0));
        vecs.push_back(mk(0, 1, 3, 'h1234, 0, 0, 0,       3,  1, 1, 0, 0, 0,       'hDEAD, 0));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,       3,  1, 1, 1, 3, 'h1234,  'h1234, 1));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,       3,  1, 1, 0, 0, 0,       'hDEAD, 0));
        vecs.push_back(mk(0, 1, 2, 'h5555, 1, 1, 'hAAAA,  2,  0, 1, 0, 0, 0,       'hDEAD, 0));
        vecs.push_back(mk(0, 1, 2, 'h5555, 0, 0, 0,       2,  1, 1, 1, 1, 'hAAAA,  'hDEAD, 1));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,       2,  1, 1, 1, 2, 'h5555,  'h5555, 1));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,       2,  1, 1, 0, 0, 0,       'hDEAD, 0));
        vecs.push_back(mk(0, 1, 5, 'h0001, 0, 0, 0,       5,  1, 1, 0, 0, 0,       'hDEAD, 0));
        vecs.push_back(mk(0, 1, 5, 'h0002, 0, 0, 0,       5,  1, 1, 1, 5, 'h0001,  'h0001, 1));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,       5,  1, 1, 1, 5, 'h0002,  'h0002, 1));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,       5,  1, 1, 0, 0, 0,       'hDEAD, 0));
        vecs.push_back(mk(0, 1, 6, 'h6666, 1, 4, 'h4444,  4,  0, 1, 0, 0, 0,       'hDEAD, 0));
        vecs.push_back(mk(0, 1, 6, 'h6666, 0, 0, 0,       4,  1, 1, 1, 4, 'h4444,  'h4444, 1));
        vecs.push_back(mk(0, 1, 6, 'h6767, 1, 4, 'h4545,  4,  0, 1, 1, 6, 'h6666,  'hDEAD, 1));
        vecs.push_back(mk(0, 1, 6, 'h6767, 0, 0, 0,       4,  1, 1, 1, 4, 'h4545,  'h4545, 1));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,       4,  1, 1, 1, 6, 'h6767,  'hDEAD, 1));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 0,       4,  1, 1, 0, 0, 0,       'hDEAD, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].aw, vecs[i].ad, vecs[i].mv, vecs[i].mw,
                  vecs[i].md, vecs[i].ra, 7, 'hDEAD, 'hBEEF);
            @(negedge clk);
            chk($sformatf("v%0d.alu_ready", i), bus.alu_ready, vecs[i].e_ar);
            chk($sformatf("v%0d.mem_ready", i), bus.mem_ready, vecs[i].e_mr);
            chk($sformatf("v%0d.we3", i), bus.we3, vecs[i].e_we);
            chk($sformatf("v%0d.wa3", i), bus.wa3, vecs[i].e_wa);
            chk($sformatf("v%0d.wd3", i), bus.wd3, vecs[i].e_wd);
            chk($sformatf("v%0d.rd1", i), bus.rd1, vecs[i].e_rd);
            chk($sformatf("v%0d.rd2", i), bus.rd2, 'hBEEF);
            chk($sformatf("v%0d.count", i), count, vecs[i].e_cnt);
            chk($sformatf("v%0d.empty", i), empty, (vecs[i].e_cnt == 0) ? 1 : 0);
            @(posedge clk);
            #1;
        end

        // ALU held valid with addresses 1..6, reset high in the first cycle.
        for (int i = 0; i <= 7; i++) begin
            drive((i == 0) ? 1 : 0, (i <= 6) ? 1 : 0, (i == 0) ? 1 : i, 'h1000 + i,
                  0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("burst%0d.alu_ready", i), bus.alu_ready, (i != 0) ? 1 : 0);
            chk($sformatf("burst%0d.full", i), full, 0);
            chk($sformatf("burst%0d.count", i), count, (i >= 2) ? 1 : 0);
            chk($sformatf("burst%0d.wa3", i), bus.wa3, (i >= 2) ? i - 1 : 0);
            chk($sformatf("burst%0d.wd3", i), bus.wd3, (i >= 2) ? 'h1000 + i - 1 : 0);
            @(posedge clk);
            #1;
        end

        // Reset while writes are pending: nothing may drain afterwards.
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, i, 'h3000 + i, 0, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end
        drive(1, 1, 4, 'h3004, 1, 5, 'h3005, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst.alu_ready", bus.alu_ready, 0);
        chk("midrst.mem_ready", bus.mem_ready, 0);
        chk("midrst.we3", bus.we3, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 3, 3, 'h5A5A, 'h5A5A);
            @(negedge clk);
            chk($sformatf("postrst%0d.count", i), count, 0);
            chk($sformatf("postrst%0d.we3", i), bus.we3, 0);
            chk($sformatf("postrst%0d.rd1", i), bus.rd1, 'h5A5A);
            @(posedge clk);
            #1;
        end

        // Write to register 0.
        drive(0, 1, 0, 'hFFFF, 0, 0, 0, 0, 0, 'h1357, 'h1357);
        @(negedge clk);
        chk("zero.alu_ready", bus.alu_ready, 1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1357, 'h1357);
        @(negedge clk);
`ifdef WBQ_ZERO_DROP_EN
        chk("zero.count", count, 0);
        chk("zero.we3", bus.we3, 0);
        chk("zero.rd1", bus.rd1, 0);
`else
        chk("zero.count", count, 1);
        chk("zero.we3", bus.we3, 1);
        chk("zero.wa3", bus.wa3, 0);
        chk("zero.wd3", bus.wd3, 'hFFFF);
        chk("zero.rd1", bus.rd1, 'hFFFF);
`endif
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1357, 'h1357);
        @(negedge clk);
        chk("zero.drained", bus.we3, 0);
        @(posedge clk);
        #1;

        // Randomized traffic against the queue model.
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            av  = 1'($urandom_range(0, 1));
            mv  = ($urandom_range(0, 2) == 0);
            aw  = R'($urandom_range(0, 7));
            mw  = R'($urandom_range(0, 7));
            ad  = N'($urandom);
            md  = N'($urandom);
            ra1 = R'($urandom_range(0, 7));
            ra2 = R'($urandom_range(0, 7));
            rf1 = N'($urandom);
            rf2 = N'($urandom);
            drive(rst, av, aw, ad, mv, mw, md, ra1, ra2, rf1, rf2);
            @(negedge clk);
            e_full = (exp_q.size() == D);
            e_mr   = !rst && !e_full;
            e_ar   = e_mr && !mv;
            e_we   = !rst && (exp_q.size() != 0);
            e_wa   = e_we ? exp_q[0][R+N-1:N] : '0;
            e_wd   = e_we ? exp_q[0][N-1:0] : '0;
            chk($sformatf("rnd%0d.alu_ready", c), bus.alu_ready, e_ar);
            chk($sformatf("rnd%0d.mem_ready", c), bus.mem_ready, e_mr);
            chk($sformatf("rnd%0d.we3", c), bus.we3, e_we);
            chk($sformatf("rnd%0d.wa3", c), bus.wa3, e_wa);
            chk($sformatf("rnd%0d.wd3", c), bus.wd3, e_wd);
            chk($sformatf("rnd%0d.rd1", c), bus.rd1, fwd(ra1, rf1));
            chk($sformatf("rnd%0d.rd2", c), bus.rd2, fwd(ra2, rf2));
            chk($sformatf("rnd%0d.count", c), count, exp_q.size());
            chk($sformatf("rnd%0d.full", c), full, e_full);
            chk($sformatf("rnd%0d.empty", c), empty, (exp_q.size() == 0) ? 1 : 0);
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (mv && e_mr) model_push(mw, md);
                else if (av && e_ar) model_push(aw, ad);
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
